// File: rtl/instruction_fetch_stage_if.sv
// Fetch stage bus: redirect/stall controls, instruction memory
// port and the IF/ID register outputs.
interface instruction_fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              freeze;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_instr;
  logic              if_valid;
  logic [31:0]       fetch_count;

  modport master (
    output freeze,
    output branch_taken,
    output branch_addr,
    output imem_instr,
    input  imem_addr,
    input  if_pc,
    input  if_instr,
    input  if_valid,
    input  fetch_count
  );

  modport slave (
    input  freeze,
    input  branch_taken,
    input  branch_addr,
    input  imem_instr,
    output imem_addr,
    output if_pc,
    output if_instr,
    output if_valid,
    output fetch_count
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch: owns the word-addressed PC, fetches from
// a combinational imem and fills the IF/ID register.
module instruction_fetch_stage #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input logic clk,
  input logic rst,
  instruction_fetch_stage_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } if_id_t;

  state_t            state;
  if_id_t            if_id;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [31:0]       count;

  assign pc_inc = pc + ADDR_W'(1);

  // PC, IF/ID register, valid FSM and fetch counter; branch beats freeze
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      if_id.pc <= '0;
      if_id.instr <= NOP_INSTR;
      state    <= EMPTY;
      count    <= '0;
    end else begin
      priority case (1'b1)
        bus.branch_taken: begin
          pc          <= bus.branch_addr;
          if_id.pc    <= '0;
          if_id.instr <= NOP_INSTR;
          state       <= EMPTY;
        end
        bus.freeze: begin
          pc    <= pc;
          state <= state;
        end
        default: begin
          pc          <= pc_inc;
          if_id.pc    <= pc_inc;
          if_id.instr <= bus.imem_instr;
          state       <= FULL;
          count       <= count + 32'd1;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_pc       = if_id.pc;
  assign bus.if_instr    = if_id.instr;
  assign bus.if_valid    = (state == FULL);
  assign bus.fetch_count = count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed
// table, async reset sequence and random run vs a model.
module tb_instruction_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instruction_fetch_stage #(
    .ADDR_W(32),
    .DATA_W(32),
    .RESET_PC(32'h0),
    .NOP_INSTR(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hA000_0000 | (a & 32'h0FFF_FFFF);
  endfunction

  assign bus.imem_instr = mem(bus.imem_addr);

  typedef struct {
    logic        fr;
    logic        br;
    logic [31:0] ba;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic        v;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a,
                         input logic [31:0] i, input logic [31:0] p,
                         input logic v, input logic [31:0] c);
    chk({tag, ".imem_addr"}, bus.imem_addr, a);
    chk({tag, ".if_instr"}, bus.if_instr, i);
    chk({tag, ".if_pc"}, bus.if_pc, p);
    chk({tag, ".if_valid"}, {31'd0, bus.if_valid}, {31'd0, v});
    chk({tag, ".fetch_count"}, bus.fetch_count, c);
  endtask

  task automatic step(input logic fr, input logic br,
                      input logic [31:0] ba);
    bus.freeze       = fr;
    bus.branch_taken = br;
    bus.branch_addr  = ba;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.freeze = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] m_pc, m_instr, m_ifpc, m_cnt;
  logic        m_v;

  initial begin
    tbl[0]  = '{0, 0, 0,         1, 32'hA0000000, 1, 1, 1};
    tbl[1]  = '{0, 0, 0,         2, 32'hA0000001, 2, 1, 2};
    tbl[2]  = '{0, 0, 0,         3, 32'hA0000002, 3, 1, 3};
    tbl[3]  = '{0, 0, 0,         4, 32'hA0000003, 4, 1, 4};
    tbl[4]  = '{0, 0, 0,         5, 32'hA0000004, 5, 1, 5};
    tbl[5]  = '{1, 0, 0,         5, 32'hA0000004, 5, 1, 5};
    tbl[6]  = '{1, 0, 0,         5, 32'hA0000004, 5, 1, 5};
    tbl[7]  = '{0, 0, 0,         6, 32'hA0000005, 6, 1, 6};
    tbl[8]  = '{0, 0, 0,         7, 32'hA0000006, 7, 1, 7};
    tbl[9]  = '{0, 1, 32'h40,    32'h40, 0, 0, 0, 7};
    tbl[10] = '{0, 0, 0,         32'h41, 32'hA0000040, 32'h41, 1, 8};
    tbl[11] = '{1, 1, 32'h10,    32'h10, 0, 0, 0, 8};
    tbl[12] = '{1, 0, 0,         32'h10, 0, 0, 0, 8};
    tbl[13] = '{0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 8};
    tbl[14] = '{0, 0, 0,         0, 32'hAFFFFFFF, 0, 1, 9};
    tbl[15] = '{0, 0, 0,         1, 32'hA0000000, 1, 1, 10};

    bus.freeze = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr = '0;
    #2;
    chk_all("reset", 0, 0, 0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      step(tbl[k].fr, tbl[k].br, tbl[k].ba);
      chk_all($sformatf("vec%0d", k), tbl[k].addr, tbl[k].instr,
              tbl[k].ifpc, tbl[k].v, tbl[k].cnt);
    end

    // async reset mid-run with a redirect pending
    step(0, 1, 32'h1E);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("pre_rst.imem_addr", bus.imem_addr, 32'h20);
    #2;
    bus.branch_taken = 1'b1;
    bus.branch_addr = 32'h55;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 1'b0, 0);
    @(posedge clk);
    #1;
    chk("rst_hold.imem_addr", bus.imem_addr, 0);
    bus.branch_taken = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0);
    chk_all("post_rst", 1, 32'hA0000000, 1, 1'b1, 1);

    // random run against a rule-level model
    do_reset();
    m_pc = 0; m_instr = 0; m_ifpc = 0; m_v = 0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      logic        fr, br;
      logic [31:0] ba;
      fr = ($urandom_range(99) < 30);
      br = ($urandom_range(99) < 10);
      ba = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE - 32'($urandom_range(2))
                                    : $urandom;
      step(fr, br, ba);
      if (br) begin
        m_pc = ba; m_instr = 0; m_ifpc = 0; m_v = 0;
      end else if (!fr) begin
        m_instr = mem(m_pc);
        m_pc = m_pc + 1;
        m_ifpc = m_pc;
        m_v = 1;
        m_cnt = m_cnt + 1;
      end
      chk_all($sformatf("rnd%0d", n), m_pc, m_instr, m_ifpc, m_v, m_cnt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction fetch stage of the processor pipeline. It owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. It supports pipeline freeze (hazard stall) and branch redirect with a flush, and keeps a count of fetches delivered downstream.

## Interface

Parameters:
- ADDR_W, 32, width of the program counter and memory address.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 0, instruction value inserted on flush and reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- freeze  input  1  hazard stall; holds PC and IF/ID register.
- branch_taken  input  1  redirect request from execute; flushes IF/ID.
- branch_addr  input  ADDR_W  redirect target word address.
- imem_addr  output  ADDR_W  word address to instruction memory (equals PC).
- imem_instr  input  DATA_W  instruction returned combinationally for imem_addr.
- if_pc  output  ADDR_W  PC+1 of the instruction in IF/ID.
- if_instr  output  DATA_W  registered instruction.
- if_valid  output  1  IF/ID holds a real fetched instruction.
- fetch_count  output  32  number of instructions accepted into IF/ID.

## Operation

- Addressing is by word: sequential PC advances by 1, not 4.
- imem_addr is driven directly from the PC register (no combinational path from inputs).
- Per rising edge, priority highest first:
  - branch_taken=1: PC <= branch_addr; if_instr <= NOP_INSTR; if_valid <= 0; if_pc <= 0; fetch_count unchanged. Overrides freeze.
  - freeze=1: PC, if_instr, if_pc, if_valid, fetch_count all hold.
  - otherwise: PC <= PC+1; if_instr <= imem_instr; if_pc <= PC+1; if_valid <= 1; fetch_count <= fetch_count+1.
- PC arithmetic is modulo 2^ADDR_W: PC = all-ones advances to 0, no error flag.
- if_pc is computed with the same modulo rule (PC = all-ones gives if_pc = 0).
- fetch_count wraps modulo 2^32.
- Two-state machine for if_valid: EMPTY (after reset or flush) -> FULL on an unfrozen, non-branch edge; FULL -> EMPTY on branch_taken; freeze holds the state.
- branch_addr is sampled only on edges where branch_taken=1.

## Timing

- Reset (async assert, released synchronously by the system): PC=RESET_PC, imem_addr=RESET_PC, if_instr=NOP_INSTR, if_pc=0, if_valid=0, fetch_count=0. Outputs take reset values immediately on rst assertion, without waiting for clk.
- Reset asserted mid-operation discards the IF/ID contents and any pending redirect.
- Latency: the instruction at address A appears on if_instr one edge after the cycle in which imem_addr=A.
- Branch penalty: the edge that samples branch_taken yields one bubble (if_valid=0). The target's instruction appears on the following edge, provided freeze=0.
- branch_taken and freeze high together: the branch is taken and the freeze is ignored for that edge.
- Freeze held N cycles: imem_addr and all outputs are stable for N edges and resume with no lost or duplicated fetch.

## Test plan

- Reset and free-run, using a memory model that returns 0xA0000000|addr. Release rst and run 3 edges -> imem_addr reads 0,1,2,3. if_instr reads 0xA0000000, 0xA0000001, 0xA0000002. if_pc reads 1,2,3. if_valid=1 from edge 1. fetch_count=3.
- Freeze: at PC=5, hold freeze for 2 cycles -> imem_addr stays 5, if_instr stays 0xA0000004, fetch_count stays constant. On release, the next edge gives if_instr=0xA0000005.
- Branch: at PC=7, pulse branch_taken with branch_addr=0x40 -> next edge gives if_valid=0, if_instr=0, imem_addr=0x40. The following edge gives if_instr=0xA0000040 and if_pc=0x41.
- Branch with freeze: freeze=1 and branch_taken=1 with branch_addr=0x10 on the same edge -> PC=0x10 and if_valid=0. fetch_count is unchanged.
- Wrap: load PC=0xFFFFFFFF via a branch, then run 1 edge -> if_instr=0xAFFFFFFF, if_pc=0, imem_addr=0.
- Async reset mid-run: assert rst between edges at PC=0x20 -> imem_addr=0, if_valid=0, and fetch_count=0 before the next clk edge.
